// File: rtl/hs32_banked_sram_ctl.sv
// hs32_banked_sram_ctl: arbitrates the HS32 CPU port and the Wishbone slave onto NBANKS
// word-interleaved 1RW SRAM macros, with one registered access outstanding at a time.
module hs32_banked_sram_ctl #(
    parameter int NBANKS = 4,
    parameter int AW = 8
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_adr_i,
    input  logic [31:0]            wbs_dat_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [31:0]            cpu_addr,
    input  logic [3:0]             cpu_wmask,
    input  logic [31:0]            cpu_dtw,
    output logic                   cpu_ready,
    output logic [31:0]            cpu_dtr,
    output logic [NBANKS-1:0]      sram_csb_o,
    output logic [NBANKS-1:0]      sram_web_o,
    output logic [4*NBANKS-1:0]    sram_wmask_o,
    output logic [AW*NBANKS-1:0]   sram_addr_o,
    output logic [32*NBANKS-1:0]   sram_din_o,
    input  logic [32*NBANKS-1:0]   sram_dout_i,
    output logic                   busy_o
);
    localparam int LB = $clog2(NBANKS);
    localparam int BW = (LB == 0) ? 1 : LB;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              r_state, w_next;
    logic                w_wb_req, w_grant, w_grant_wb, w_we, w_inr;
    logic [31:0]         w_adr, w_word, w_dat, w_rdata;
    logic [3:0]          w_mask;
    logic [BW-1:0]       w_bank;
    logic [AW-1:0]       w_row;
    logic                r_last_cpu, r_wb, r_we, r_inr, r_ack, r_rdy;
    logic [BW-1:0]       r_bank;
    logic [NBANKS-1:0]   r_csb, r_web;
    logic [4*NBANKS-1:0] r_wmask;
    logic [AW*NBANKS-1:0] r_addr;
    logic [32*NBANKS-1:0] r_din;
    logic [31:0]         r_wb_dat, r_cpu_dat;

    assign w_wb_req   = wbs_cyc_i & wbs_stb_i;
    assign w_grant    = (r_state == IDLE) & (w_wb_req | cpu_req);
    // On a tie WB wins only when the CPU held the previous grant.
    assign w_grant_wb = w_wb_req & (~cpu_req | r_last_cpu);
    assign w_adr      = w_grant_wb ? wbs_adr_i : cpu_addr;
    assign w_we       = w_grant_wb ? wbs_we_i : cpu_we;
    assign w_mask     = w_grant_wb ? wbs_sel_i : cpu_wmask;
    assign w_dat      = w_grant_wb ? wbs_dat_i : cpu_dtw;
    assign w_word     = w_adr >> 2;
    assign w_bank     = BW'(w_word & 32'(NBANKS - 1));
    assign w_row      = AW'(w_word >> LB);
    assign w_inr      = (w_word >> (LB + AW)) == 32'd0;
    assign w_rdata    = (r_inr & ~r_we) ? sram_dout_i[32*r_bank +: 32] : 32'd0;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == IDLE) ? (w_grant ? ACCESS : IDLE) : (r_state == ACCESS) ? RESP : IDLE;
    end

    always_comb begin
        busy_o       = r_state != IDLE;
        wbs_ack_o    = r_ack;
        cpu_ready    = r_rdy;
        wbs_dat_o    = r_ack ? w_rdata : r_wb_dat;
        cpu_dtr      = r_rdy ? w_rdata : r_cpu_dat;
        sram_csb_o   = r_csb;
        sram_web_o   = r_web;
        sram_wmask_o = r_wmask;
        sram_addr_o  = r_addr;
        sram_din_o   = r_din;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_last_cpu <= 1'b1;
            r_wb       <= 1'b0;
            r_we       <= 1'b0;
            r_inr      <= 1'b0;
            r_bank     <= '0;
            r_ack      <= 1'b0;
            r_rdy      <= 1'b0;
            r_csb      <= '1;
            r_web      <= '1;
            r_wmask    <= '0;
            r_addr     <= '0;
            r_din      <= '0;
            r_wb_dat   <= 32'd0;
            r_cpu_dat  <= 32'd0;
        end else begin
            r_csb   <= '1;
            r_web   <= '1;
            r_wmask <= '0;
            r_addr  <= '0;
            r_din   <= '0;
            // Ack/ready only if the requester still holds its request through ACCESS.
            r_ack   <= (r_state == ACCESS) & r_wb & wbs_cyc_i;
            r_rdy   <= (r_state == ACCESS) & ~r_wb & cpu_req;
            if (w_grant) begin
                r_wb       <= w_grant_wb;
                r_last_cpu <= ~w_grant_wb;
                r_we       <= w_we;
                r_bank     <= w_bank;
                r_inr      <= w_inr;
                if (w_inr) begin
                    r_csb[w_bank]              <= 1'b0;
                    r_web[w_bank]              <= ~w_we;
                    r_wmask[4*w_bank +: 4]     <= w_we ? w_mask : 4'hF;
                    r_addr[AW*w_bank +: AW]    <= w_row;
                    r_din[32*w_bank +: 32]     <= w_dat;
                end
            end
            if (r_ack) r_wb_dat <= w_rdata;
            if (r_rdy) r_cpu_dat <= w_rdata;
        end
    end
endmodule
